// File: rtl/nibble_packer_ctrl.sv
// rtl/nibble_packer_ctrl.sv - packs a stream of 4-bit nibbles into 32-bit words with flush/padding
module nibble_packer_ctrl #(
  parameter logic [3:0] PAD_NIBBLE = 4'h0
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        inEnable,
  input  logic [3:0]  inData,
  input  logic        inValid,
  output logic        outReady,
  input  logic        inFlush,
  output logic [2:0]  outSel,
  output logic [31:0] outData,
  output logic        outValid,
  input  logic        inReady,
  output logic [3:0]  outNibbles,
  output logic        outPadded
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q;
  logic [2:0]  sel_q;
  logic [31:0] data_q;
  logic        valid_q;
  logic [3:0]  nibbles_q;
  logic        padded_q;

  logic        accept;
  logic [3:0]  fill_cnt_d;
  logic [31:0] wr_word_d;
  logic [31:0] pad_word_d;

  // Upstream handshake; held low while reset is asserted and while a word waits downstream
  assign outReady = resetb & inEnable & (state_q != HOLD);
  assign accept   = inValid & outReady;

  // Word with this cycle's nibble written, and the same word with all later slots padded
  always_comb begin
    fill_cnt_d = {1'b0, sel_q} + {3'b000, accept};
    wr_word_d  = (state_q == IDLE) ? 32'h0 : data_q;
    for (int k = 0; k < 8; k++) begin
      if (accept && (3'(k) == sel_q)) begin
        wr_word_d[31-4*k -: 4] = inData;
      end
    end
    pad_word_d = wr_word_d;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) >= fill_cnt_d) begin
        pad_word_d[31-4*k -: 4] = PAD_NIBBLE;
      end
    end
  end

  // Packing FSM with registered outputs; disable acts as a synchronous clear
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= IDLE;
      sel_q     <= 3'd0;
      data_q    <= 32'h0;
      valid_q   <= 1'b0;
      nibbles_q <= 4'd0;
      padded_q  <= 1'b0;
    end else if (!inEnable) begin
      state_q   <= IDLE;
      sel_q     <= 3'd0;
      data_q    <= 32'h0;
      valid_q   <= 1'b0;
      nibbles_q <= 4'd0;
      padded_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, FILL: begin
          if (accept && (sel_q == 3'd7)) begin
            // Eighth nibble closes a full word even if a flush arrives with it
            state_q   <= HOLD;
            data_q    <= wr_word_d;
            nibbles_q <= 4'd8;
            padded_q  <= 1'b0;
            sel_q     <= 3'd0;
            valid_q   <= 1'b1;
          end else if (inFlush && (fill_cnt_d != 4'd0)) begin
            state_q   <= HOLD;
            data_q    <= pad_word_d;
            nibbles_q <= fill_cnt_d;
            padded_q  <= 1'b1;
            sel_q     <= 3'd0;
            valid_q   <= 1'b1;
          end else if (accept) begin
            state_q <= FILL;
            data_q  <= wr_word_d;
            sel_q   <= sel_q + 3'd1;
          end
        end
        HOLD: begin
          if (inReady) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= 3'd0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign outSel     = sel_q;
  assign outData    = data_q;
  assign outValid   = valid_q;
  assign outNibbles = nibbles_q;
  assign outPadded  = padded_q;

endmodule

// File: tb/tb_nibble_packer_ctrl.sv
// tb/tb_nibble_packer_ctrl.sv - directed self-checking bench with a queue-based word model
module tb_nibble_packer_ctrl;

  localparam logic [3:0] PAD = 4'h0;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic        en = 1'b1;
  logic [3:0]  din = 4'h0;
  logic        vin = 1'b0;
  logic        flush = 1'b0;
  logic        rdy = 1'b1;
  logic        out_ready;
  logic [2:0]  out_sel;
  logic [31:0] out_data;
  logic        out_valid;
  logic [3:0]  out_nibbles;
  logic        out_padded;

  int checks = 0;
  int errors = 0;

  // model state: nibbles collected so far, and the word waiting downstream
  logic [3:0]  nq[$];
  bit          m_hold = 1'b0;
  logic [31:0] m_word = 32'h0;
  logic [3:0]  m_nib  = 4'h0;
  bit          m_pad  = 1'b0;

  nibble_packer_ctrl #(.PAD_NIBBLE(PAD)) dut (
    .clk(clk), .resetb(resetb), .inEnable(en), .inData(din), .inValid(vin),
    .outReady(out_ready), .inFlush(flush), .outSel(out_sel), .outData(out_data),
    .outValid(out_valid), .inReady(rdy), .outNibbles(out_nibbles), .outPadded(out_padded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: collect nibbles, emit a word at 8 nibbles or on a flush
  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      nq.delete();
      m_hold = 1'b0;
      m_word = 32'h0;
      m_nib  = 4'h0;
      m_pad  = 1'b0;
    end else if (!en) begin
      nq.delete();
      m_hold = 1'b0;
    end else if (m_hold) begin
      if (rdy) m_hold = 1'b0;
    end else begin
      if (vin) nq.push_back(din);
      if (nq.size() == 8 || (flush && nq.size() > 0)) begin
        m_word = 32'h0;
        for (int i = 0; i < 8; i++)
          m_word[31-4*i -: 4] = (i < nq.size()) ? nq[i] : PAD;
        m_nib  = 4'(nq.size());
        m_pad  = (nq.size() < 8);
        m_hold = 1'b1;
        nq.delete();
      end
    end
  end

  // compare process, away from the active edge
  always @(negedge clk) begin
    check("ready", {31'h0, out_ready}, {31'h0, resetb && en && !m_hold});
    check("valid", {31'h0, out_valid}, {31'h0, resetb && m_hold});
    check("sel",   {29'h0, out_sel},   (!resetb || m_hold) ? 32'h0 : 32'(nq.size()));
    if (!resetb) begin
      check("rst_data", out_data, 32'h0);
      check("rst_nib",  {28'h0, out_nibbles}, 32'h0);
      check("rst_pad",  {31'h0, out_padded}, 32'h0);
    end else if (m_hold) begin
      check("data", out_data, m_word);
      check("nib",  {28'h0, out_nibbles}, {28'h0, m_nib});
      check("pad",  {31'h0, out_padded}, {31'h0, m_pad});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [3:0] d);
    vin = 1'b1; din = d; tick(); vin = 1'b0;
  endtask

  initial begin
    #1;
    check("lit_rst_valid", {31'h0, out_valid}, 32'h0);
    check("lit_rst_ready", {31'h0, out_ready}, 32'h0);
    check("lit_rst_data",  out_data, 32'h0);
    tick(); tick();
    resetb = 1'b1;
    tick();

    // full word 1..8
    for (int i = 1; i <= 8; i++) push(4'(i));
    check("lit_full_data", out_data, 32'h12345678);
    check("lit_full_nib",  {28'h0, out_nibbles}, 32'd8);
    check("lit_full_pad",  {31'h0, out_padded}, 32'd0);
    check("lit_full_valid", {31'h0, out_valid}, 32'd1);
    tick();
    check("lit_full_done", {31'h0, out_valid}, 32'd0);
    check("lit_full_ready", {31'h0, out_ready}, 32'd1);

    // flush after A, B
    push(4'hA); push(4'hB);
    flush = 1'b1; tick(); flush = 1'b0;
    check("lit_flush_data", out_data, 32'hAB000000);
    check("lit_flush_nib",  {28'h0, out_nibbles}, 32'd2);
    check("lit_flush_pad",  {31'h0, out_padded}, 32'd1);
    tick();

    // flush alone in IDLE is ignored
    flush = 1'b1; tick(); flush = 1'b0;
    check("lit_idle_flush", {31'h0, out_valid}, 32'd0);

    // backpressure with upstream still offering a nibble
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) push(4'(i + 9));
    vin = 1'b1; din = 4'h5;
    for (int i = 0; i < 5; i++) begin
      check("lit_bp_data", out_data, 32'h9ABCDEF0);
      check("lit_bp_ready", {31'h0, out_ready}, 32'd0);
      flush = (i == 2);
      tick();
    end
    flush = 1'b0; vin = 1'b0; rdy = 1'b1;
    check("lit_bp_still", {31'h0, out_valid}, 32'd1);
    tick();
    check("lit_bp_done", {31'h0, out_valid}, 32'd0);

    // 8th nibble together with flush gives an unpadded word
    for (int i = 1; i <= 7; i++) push(4'(i));
    flush = 1'b1; push(4'h8); flush = 1'b0;
    check("lit_sim_nib", {28'h0, out_nibbles}, 32'd8);
    check("lit_sim_pad", {31'h0, out_padded}, 32'd0);
    tick();

    // accept plus flush in IDLE
    flush = 1'b1; push(4'hC); flush = 1'b0;
    check("lit_one_data", out_data, 32'hC0000000);
    check("lit_one_nib",  {28'h0, out_nibbles}, 32'd1);
    tick();

    // async reset mid-word
    push(4'h1); push(4'h2); push(4'h3);
    #1 resetb = 1'b0;
    #1;
    check("lit_ar_sel",   {29'h0, out_sel}, 32'd0);
    check("lit_ar_data",  out_data, 32'h0);
    check("lit_ar_ready", {31'h0, out_ready}, 32'd0);
    tick();
    resetb = 1'b1;
    for (int i = 8; i >= 1; i--) push(4'(i));
    check("lit_ar_word", out_data, 32'h87654321);
    tick();

    // disable while holding
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) push(4'hE);
    check("lit_dis_hold", {31'h0, out_valid}, 32'd1);
    en = 1'b0; tick();
    check("lit_dis_valid", {31'h0, out_valid}, 32'd0);
    en = 1'b1; rdy = 1'b1; tick();
    check("lit_dis_idle",  {31'h0, out_ready}, 32'd1);
    check("lit_dis_none",  {31'h0, out_valid}, 32'd0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_packer_ctrl.md
NIBBLE_PACKER_CTRL -- requirements
Module: nibble_packer_ctrl

Interface
REQ-001 SHALL have parameter PAD_NIBBLE, default 4'h0, the nibble value written into unfilled slots on flush.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetb  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port inEnable  input  1  block enable; low means synchronous clear to IDLE.
REQ-005 SHALL have port inData  input  4  nibble from upstream.
REQ-006 SHALL have port inValid  input  1  upstream nibble valid.
REQ-007 SHALL have port outReady  output  1  upstream may transfer; a nibble is accepted when inValid=1 and outReady=1.
REQ-008 SHALL have port inFlush  input  1  close the partial word, padding the remaining slots.
REQ-009 SHALL have port outSel  output  3  current demux slot select, equal to the number of nibbles already written in the word.
REQ-010 SHALL have port outData  output  32  assembled word.
REQ-011 SHALL have port outValid  output  1  outData valid.
REQ-012 SHALL have port inReady  input  1  downstream ready; a word transfers when outValid=1 and inReady=1.
REQ-013 SHALL have port outNibbles  output  4  number of real (non-pad) nibbles in outData, range 1..8.
REQ-014 SHALL have port outPadded  output  1  high when outData was closed by a flush.

Function
REQ-015 SHALL implement FSM states IDLE (0 nibbles), FILL (1..7 nibbles) and HOLD (word valid).
REQ-016 SHALL write nibble k (k = outSel at accept, 0..7) to outData[31-4k : 28-4k], so the first nibble lands in [31:28], matching the 1:8 nibble demux mapping.
REQ-017 SHALL clear outData to 0 on the first accept in IDLE, then write slot 0.
REQ-018 SHALL drive outReady = inEnable AND (state != HOLD), combinationally.
REQ-019 SHALL, on accept, increment outSel; the 8th accept (outSel=7) goes to HOLD with outSel wrapping to 0, outNibbles=8 and outPadded=0.
REQ-020 SHALL go IDLE->FILL on the first accept; FILL stays in FILL until the 8th accept or a flush.
REQ-021 SHALL hold outValid=1 only in HOLD, with outData, outNibbles and outPadded stable until transfer.
REQ-022 SHALL go HOLD->IDLE on the cycle after transfer, and accept no nibble in HOLD (1-cycle bubble; throughput 9 cycles per word).
REQ-023 SHALL apply flush in FILL as follows: write PAD_NIBBLE to slots outSel..7 in one cycle, set outNibbles to the real nibble count, set outPadded=1, go HOLD, and set outSel=0.
REQ-024 SHALL handle a flush coincident with an accept in FILL by writing the nibble first, then padding the rest; if that nibble fills slot 7, the result is a normal full word with outPadded=0.
REQ-025 SHALL handle a flush coincident with an accept in IDLE by producing a word with outNibbles=1 and outPadded=1.
REQ-026 SHALL ignore a flush in IDLE without an accept, and in HOLD.
REQ-027 SHALL, when inEnable=0 in any state, go IDLE on the next edge, set outValid=0 and outSel=0, and discard any partial or held word.

Reset
REQ-028 SHALL, while resetb=0, immediately force state=IDLE, outSel=0, outData=0, outValid=0, outNibbles=0, outPadded=0 and outReady=0.
REQ-029 SHALL start accepting on the first rising edge after resetb deasserts, provided inEnable=1.
REQ-030 SHALL, on reset mid-word or in HOLD, lose all data with no output pulse.

Verification
REQ-031 SHALL verify full word: 8 back-to-back nibbles 1..8 with inReady=1 -> outValid for 1 cycle, outData=32'h12345678, outNibbles=8, outPadded=0, then outReady high again.
REQ-032 SHALL verify flush: nibbles A, B, then inFlush (PAD_NIBBLE=0) -> outData=32'hAB000000, outNibbles=2, outPadded=1.
REQ-033 SHALL verify backpressure: full word with inReady=0 for 5 cycles -> outValid and outData held stable, outReady=0, no nibble lost; transfer on the 6th cycle.
REQ-034 SHALL verify the simultaneous case: 7 nibbles, then 8th nibble with inFlush in the same cycle -> outPadded=0, outNibbles=8.
REQ-035 SHALL verify async reset: resetb pulled low mid-cycle after 3 nibbles -> all outputs 0 immediately; the next 8 nibbles form a clean word.
REQ-036 SHALL verify disable: inEnable=0 while in HOLD -> outValid=0 on the next edge, FSM returns to IDLE, and no transfer occurs.
